adder_resp_checker: RTL and testbench
=====================================

Name: adder_resp_checker

Overview:
- Synthesizable response checker that sits on the adder's output side of `my_if`. It is the consuming end of the interface our stimulus generator drives.
- It samples the operands (`in0`, `in1`) and the adder results (`sum_out`, `carry_out`). It computes the expected sum internally, accounting for a configurable DUT result latency, and counts passes and failures.
- It captures the first mismatch and signals completion after a programmed number of transactions.
- Used in benches and in self-checking FPGA builds alongside the adder DUT.

Parameters:
- WIDTH, 4: operand and sum width in bits.
- LATENCY, 0: cycles between operand presentation and valid DUT result. Legal range 0..4.
- CNT_W, 16: width of the transaction and result counters.

Ports:
- clk  in  1  system clock; all state updates on the rising edge.
- rst  in  1  synchronous, active-high reset.
- start  in  1  one-cycle pulse; begins a checking run.
- num_txn  in  CNT_W  transactions to check; sampled only on an accepted start.
- in_valid  in  1  operands on in0/in1 are a valid transaction this cycle.
- in0  in  WIDTH  operand 0.
- in1  in  WIDTH  operand 1.
- sum_out  in  WIDTH  DUT sum.
- carry_out  in  1  DUT carry.
- busy  out  1  high in RUN.
- done  out  1  high in DONE.
- pass_cnt  out  CNT_W  matching results.
- fail_cnt  out  CNT_W  mismatching results.
- err_flag  out  1  at least one mismatch this run.
- err_exp  out  WIDTH+1  expected {carry,sum} of the first mismatch.
- err_got  out  WIDTH+1  observed {carry_out,sum_out} of the first mismatch.

Behaviour:
- Reset:
  - FSM goes to IDLE.
  - All outputs are 0.
  - Delay-line valid bits and the target register are cleared.
  - Reset mid-run aborts the run immediately, with no done pulse.
- FSM states and transitions:
  - IDLE: start moves to RUN.
  - RUN: moves to DONE when the checked count equals target.
  - DONE: start moves to RUN; otherwise holds.
- Accepted start (in IDLE or DONE):
  - Latches num_txn into target.
  - Clears pass_cnt, fail_cnt, err_flag, err_exp, err_got and the delay line.
  - Enters RUN the next cycle. start during RUN is ignored.
- num_txn = 0: on the first RUN cycle the FSM goes to DONE; no transactions are checked.
- Operand capture: in_valid is honoured only in RUN; in IDLE and DONE it is ignored and nothing enters the delay line.
- Expected value: exp = zero-extended in0 + zero-extended in1, WIDTH+1 bits, where the MSB is the carry.
- Delay line:
  - LATENCY stages of {valid, exp}, shifting every cycle.
  - LATENCY = 0: exp is compared in the same cycle against {carry_out, sum_out}.
- Compare: happens when the delay-line output valid is high AND the number checked so far is below target. Results arriving after the count is reached are discarded.
- Match or mismatch on a compare:
  - Match: pass_cnt + 1 on the next edge.
  - Mismatch: fail_cnt + 1 on the next edge.
  - First mismatch of a run: err_flag is set and err_exp/err_got are latched. Later mismatches do not overwrite them.
- Counter saturation: pass_cnt and fail_cnt saturate at all-ones. The internal checked count still advances, so the run always terminates.
- Completion timing: the transition to DONE occurs the cycle after the final compare, so done and the final counters are visible together.
- Outputs in DONE: counters and capture registers hold until the next start or rst.
- Throughput: one transaction per cycle; back-to-back in_valid is fully supported.

Test Plan:
- WIDTH=4, LATENCY=0, num_txn=3; operands (3,4), (15,1), (9,9) with correct results (7/0, 0/1, 2/1) -> pass_cnt=3, fail_cnt=0, err_flag=0, done=1 one cycle after the third transaction.
- LATENCY=0, num_txn=2; (7,8) with DUT sum=14, carry=0, then (1,1) with sum 2 -> fail_cnt=1, pass_cnt=1, err_flag=1, err_exp=5'h0F, err_got=5'h0E.
- LATENCY=2, num_txn=4; back-to-back operands, DUT results delayed exactly 2 cycles -> pass_cnt=4. The same run with the DUT delayed by 1 cycle -> fail_cnt>0 and err_flag=1.
- num_txn=0 start -> done=1 after RUN for one cycle; in_valid pulses afterwards leave pass_cnt=fail_cnt=0.
- rst asserted after 2 of 5 transactions -> all outputs 0, FSM in IDLE. A new start with num_txn=1 and one correct transaction -> pass_cnt=1, done=1.
- In DONE, 3 extra in_valid transactions with wrong sums -> counters unchanged. A start pulse during RUN -> ignored, and target is not reloaded.

Source files
------------

// File: rtl/adder_resp_checker.sv
// Response checker for the adder sitting behind my_if. It rebuilds the
// expected {carry,sum} from the operands, delays it to line up with the
// DUT result, counts matches/mismatches and captures the first mismatch.
module adder_resp_checker #(
   parameter int WIDTH   = 4,
   parameter int LATENCY = 0,
   parameter int CNT_W   = 16
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             start,
   input  logic [CNT_W-1:0] num_txn,
   input  logic             in_valid,
   input  logic [WIDTH-1:0] in0,
   input  logic [WIDTH-1:0] in1,
   input  logic [WIDTH-1:0] sum_out,
   input  logic             carry_out,
   output logic             busy,
   output logic             done,
   output logic [CNT_W-1:0] pass_cnt,
   output logic [CNT_W-1:0] fail_cnt,
   output logic             err_flag,
   output logic [WIDTH:0]   err_exp,
   output logic [WIDTH:0]   err_got
);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

   state_t           state, state_nxt;
   logic             start_acc;
   logic             push;
   logic             cmp;
   logic             match;
   logic             res_v;
   logic [WIDTH:0]   exp_now;
   logic [WIDTH:0]   res_exp;
   logic [WIDTH:0]   got;
   logic [CNT_W-1:0] target;
   logic [CNT_W-1:0] chk_cnt;
   logic [CNT_W-1:0] chk_nxt;

   assign exp_now = {1'b0, in0} + {1'b0, in1};
   assign got     = {carry_out, sum_out};
   assign busy    = (state == RUN);
   assign done    = (state == DONE);

   // Delay line aligning the expected value with the DUT result latency.
   generate
      if (LATENCY == 0) begin : g_nodly
         assign res_v   = push;
         assign res_exp = exp_now;
      end else begin : g_dly
         logic [LATENCY-1:0] dv;
         logic [WIDTH:0]     de [LATENCY];

         // Valid bits are reset and flushed on every accepted start.
         always_ff @(posedge clk) begin
            if (rst || start_acc) begin
               dv <= '0;
            end else begin
               dv[0] <= push;
               for (int i = 1; i < LATENCY; i++) dv[i] <= dv[i-1];
            end
         end

         // NOTE: the payload array carries no reset; its contents are only
         // ever looked at when the matching valid bit is set.
         always_ff @(posedge clk) begin
            de[0] <= exp_now;
            for (int i = 1; i < LATENCY; i++) de[i] <= de[i-1];
         end

         assign res_v   = dv[LATENCY-1];
         assign res_exp = de[LATENCY-1];
      end
   endgenerate

   // Control decode and next-state logic.
   // NOTE: every signal gets a default before the case so no latch is inferred.
   always_comb begin
      start_acc = start && (state != RUN);
      push      = in_valid && (state == RUN);
      cmp       = (state == RUN) && res_v && (chk_cnt < target);
      match     = (res_exp == got);
      chk_nxt   = chk_cnt + CNT_W'(cmp);
      state_nxt = state;
      case (state)
         IDLE:    if (start) state_nxt = RUN;
         // Using the post-compare count lets done rise with the final counters.
         RUN:     if (chk_nxt == target) state_nxt = DONE;
         DONE:    if (start) state_nxt = RUN;
         default: state_nxt = IDLE;
      endcase
   end

   // State register.
   // NOTE: sequential state uses non-blocking assignments only.
   always_ff @(posedge clk) begin
      if (rst) state <= IDLE;
      else     state <= state_nxt;
   end

   // Run target, checked count, result counters and first-mismatch capture.
   always_ff @(posedge clk) begin
      if (rst || start_acc) begin
         target   <= rst ? '0 : num_txn;
         chk_cnt  <= '0;
         pass_cnt <= '0;
         fail_cnt <= '0;
         err_flag <= 1'b0;
         err_exp  <= '0;
         err_got  <= '0;
      end else if (cmp) begin
         chk_cnt <= chk_nxt;
         if (match) begin
            if (pass_cnt != '1) pass_cnt <= pass_cnt + 1'b1;
         end else begin
            if (fail_cnt != '1) fail_cnt <= fail_cnt + 1'b1;
            if (!err_flag) begin
               err_flag <= 1'b1;
               err_exp  <= res_exp;
               err_got  <= got;
            end
         end
      end
   end

endmodule

// File: tb/tb_adder_resp_checker.sv
// Directed bench for adder_resp_checker: one instance with LATENCY=0 and
// one with LATENCY=2, driven with hand-computed vectors.
module tb_adder_resp_checker;

   logic        clk = 1'b0;
   logic        rst = 1'b1;

   logic        start0 = 0, v0 = 0, c0 = 0;
   logic [15:0] num0 = 0;
   logic [3:0]  a0 = 0, b0 = 0, s0 = 0;
   logic        busy0, done0, eflag0;
   logic [15:0] pass0, fail0;
   logic [4:0]  eexp0, egot0;

   logic        start2 = 0, v2 = 0, c2 = 0;
   logic [15:0] num2 = 0;
   logic [3:0]  a2 = 0, b2 = 0, s2 = 0;
   logic        busy2, done2, eflag2;
   logic [15:0] pass2, fail2;
   logic [4:0]  eexp2, egot2;

   int n_total = 0;
   int n_bad   = 0;

   always #5 clk = ~clk;

   adder_resp_checker #(.WIDTH(4), .LATENCY(0), .CNT_W(16)) u_lat0 (
      .clk(clk), .rst(rst), .start(start0), .num_txn(num0), .in_valid(v0),
      .in0(a0), .in1(b0), .sum_out(s0), .carry_out(c0),
      .busy(busy0), .done(done0), .pass_cnt(pass0), .fail_cnt(fail0),
      .err_flag(eflag0), .err_exp(eexp0), .err_got(egot0));

   adder_resp_checker #(.WIDTH(4), .LATENCY(2), .CNT_W(16)) u_lat2 (
      .clk(clk), .rst(rst), .start(start2), .num_txn(num2), .in_valid(v2),
      .in0(a2), .in1(b2), .sum_out(s2), .carry_out(c2),
      .busy(busy2), .done(done2), .pass_cnt(pass2), .fail_cnt(fail2),
      .err_flag(eflag2), .err_exp(eexp2), .err_got(egot2));

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_total++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got=%0h expected=%0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic start_lat0(input logic [15:0] n);
      start0 = 1'b1;
      num0   = n;
      tick();
      start0 = 1'b0;
   endtask

   task automatic txn_lat0(input logic [3:0] a, input logic [3:0] b,
                           input logic [3:0] s, input logic c);
      v0 = 1'b1; a0 = a; b0 = b; s0 = s; c0 = c;
      tick();
      v0 = 1'b0;
   endtask

   // Four back-to-back operands; the modelled DUT returns each result d cycles later.
   task automatic run_lat2(input int d);
      logic [3:0] op_a [4] = '{4'd1, 4'd3, 4'd5, 4'd7};
      logic [3:0] op_b [4] = '{4'd2, 4'd4, 4'd6, 4'd8};
      logic [4:0] res  [4] = '{5'h03, 5'h07, 5'h0B, 5'h0F};
      start2 = 1'b1;
      num2   = 16'd4;
      tick();
      start2 = 1'b0;
      for (int k = 0; k < 8; k++) begin
         v2 = (k < 4);
         a2 = (k < 4) ? op_a[k] : 4'd0;
         b2 = (k < 4) ? op_b[k] : 4'd0;
         if (k - d >= 0 && k - d < 4) {c2, s2} = res[k-d];
         else                         {c2, s2} = 5'h00;
         tick();
      end
      v2 = 1'b0;
   endtask

   initial begin
      tick();
      tick();
      rst = 1'b0;

      check("rst_busy", busy0, 0);
      check("rst_done", done0, 0);
      check("rst_pass", pass0, 0);
      check("rst_eflag", eflag0, 0);

      // Three correct results.
      start_lat0(16'd3);
      check("t1_busy", busy0, 1);
      txn_lat0(4'd3, 4'd4, 4'd7, 1'b0);
      txn_lat0(4'd15, 4'd1, 4'd0, 1'b1);
      check("t1_not_done", done0, 0);
      txn_lat0(4'd9, 4'd9, 4'd2, 1'b1);
      check("t1_done", done0, 1);
      check("t1_pass", pass0, 3);
      check("t1_fail", fail0, 0);
      check("t1_eflag", eflag0, 0);

      // One mismatch then one match.
      start_lat0(16'd2);
      txn_lat0(4'd7, 4'd8, 4'd14, 1'b0);
      txn_lat0(4'd1, 4'd1, 4'd2, 1'b0);
      check("t2_done", done0, 1);
      check("t2_pass", pass0, 1);
      check("t2_fail", fail0, 1);
      check("t2_eflag", eflag0, 1);
      check("t2_eexp", eexp0, 5'h0F);
      check("t2_egot", egot0, 5'h0E);

      // Wrong results while in DONE are ignored.
      txn_lat0(4'd1, 4'd2, 4'd9, 1'b0);
      txn_lat0(4'd4, 4'd4, 4'd0, 1'b0);
      txn_lat0(4'd5, 4'd5, 4'd1, 1'b1);
      check("t3_pass_hold", pass0, 1);
      check("t3_fail_hold", fail0, 1);
      check("t3_egot_hold", egot0, 5'h0E);

      // num_txn = 0: one RUN cycle then DONE, later operands ignored.
      start_lat0(16'd0);
      check("t4_busy", busy0, 1);
      tick();
      check("t4_done", done0, 1);
      txn_lat0(4'd2, 4'd2, 4'd0, 1'b0);
      txn_lat0(4'd3, 4'd3, 4'd6, 1'b0);
      check("t4_pass", pass0, 0);
      check("t4_fail", fail0, 0);

      // start during RUN must not reload the target.
      start_lat0(16'd3);
      start0 = 1'b1; num0 = 16'd1;
      txn_lat0(4'd1, 4'd2, 4'd3, 1'b0);
      start0 = 1'b0;
      check("t5_still_busy", busy0, 1);
      txn_lat0(4'd8, 4'd8, 4'd0, 1'b1);
      txn_lat0(4'd6, 4'd3, 4'd9, 1'b0);
      check("t5_done", done0, 1);
      check("t5_pass", pass0, 3);

      // Reset mid-run, then a fresh single-transaction run.
      start_lat0(16'd5);
      txn_lat0(4'd2, 4'd3, 4'd5, 1'b0);
      txn_lat0(4'd9, 4'd1, 4'd10, 1'b0);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      check("t6_busy", busy0, 0);
      check("t6_done", done0, 0);
      check("t6_pass", pass0, 0);
      check("t6_fail", fail0, 0);
      check("t6_eflag", eflag0, 0);
      tick();
      check("t6_idle_busy", busy0, 0);
      start_lat0(16'd1);
      txn_lat0(4'd12, 4'd5, 4'd1, 1'b1);
      check("t6_new_pass", pass0, 1);
      check("t6_new_done", done0, 1);

      // LATENCY=2 with a correctly aligned DUT.
      run_lat2(2);
      check("l2_done", done2, 1);
      check("l2_pass", pass2, 4);
      check("l2_fail", fail2, 0);
      check("l2_eflag", eflag2, 0);

      // LATENCY=2 against a DUT that answers one cycle early.
      run_lat2(1);
      check("l2m_done", done2, 1);
      check("l2m_fail", fail2, 4);
      check("l2m_pass", pass2, 0);
      check("l2m_eflag", eflag2, 1);
      check("l2m_eexp", eexp2, 5'h03);
      check("l2m_egot", egot2, 5'h07);

      $display("test done: total=%0d bad=%0d", n_total, n_bad);
      $finish;
   end

endmodule
